fpu_result_display_seq: RTL and testbench

Upstream feeder for the two-digit seven-segment driver. It captures a 32-bit FPU result on a valid/ready handshake and presents it one byte at a time on an 8-bit `char` bus, most significant byte first. Each byte is held for a programmable dwell, so the operator can read the full word two hex digits at a time. It sits between the FPU result register and the seven-segment driver's `char` input.

---
 rtl/fpu_result_display_seq.sv | 76 +++++++
 tb/tb_fpu_result_display_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_display_seq.sv
// fpu_result_display_seq: captures a 32-bit FPU result and shows it MSB byte first on char, DWELL cycles per byte.
// Optional macro DISP_REPEAT_EN: redisplay the word continuously and accept a new word at any time.
module fpu_result_display_seq #(
    parameter int DWELL   = 50000000,
    parameter int DWELL_W = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic [1:0]  byte_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    logic [0:0]         state;
    logic [31:0]        word;
    logic [1:0]         idx;
    logic [DWELL_W-1:0] cnt;
    logic               accept;

    assign busy = (state == SHOW);

`ifdef DISP_REPEAT_EN
    assign in_ready = 1'b1;
`else
    assign in_ready = (state == IDLE);
`endif

    assign accept   = in_valid & in_ready;
    assign char     = busy ? word[{idx, 3'b000} +: 8] : 8'h00;
    assign byte_idx = idx;

    // An accept always wins over a dwell expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            word  <= 32'h0;
            idx   <= 2'd0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                word  <= in_data;
                idx   <= 2'd3;
                cnt   <= '0;
                state <= SHOW;
            end else if (state == SHOW) begin
                if (cnt == LAST) begin
                    cnt <= '0;
                    if (idx != 2'd0) begin
                        idx <= idx - 2'd1;
                    end else begin
                        done <= 1'b1;
`ifdef DISP_REPEAT_EN
                        idx  <= 2'd3;
`else
                        state <= IDLE;
`endif
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_display_seq.sv
// Scoreboard bench for fpu_result_display_seq with DWELL = 4; expected per-cycle outputs are queued at stimulus time.
module tb_fpu_result_display_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [7:0]  ch;
    logic [1:0]  bidx;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DISP_REPEAT_EN
    localparam bit SHOW_RDY = 1'b1;
`else
    localparam bit SHOW_RDY = 1'b0;
`endif

    // {char, byte_idx, busy, done, in_ready}
    typedef logic [12:0] exp_t;
    exp_t sb[$];

    fpu_result_display_seq #(.DWELL(4), .DWELL_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .char     (ch),
        .byte_idx (bidx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(logic [7:0] c, logic [1:0] b, logic bz, logic dn, logic rd);
        return {c, b, bz, dn, rd};
    endfunction

    function automatic void push_bytes(logic [31:0] w, logic rd);
        for (int k = 3; k >= 0; k--)
            repeat (4) sb.push_back(mk(w[8*k +: 8], 2'(k), 1'b1, 1'b0, rd));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t o;
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b1)) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %h want %h", i, o, mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b1));
            end
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        o = {ch, bidx, busy, done, in_ready};
        n_cmp++;
        if (o !== mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b1)) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", o, mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_single();
        exp_t o, e;
        int c = 0;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_data = 32'h3F800000;
        push_bytes(32'h3F800000, 1'b0);
        sb.push_back(mk(8'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        sb.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b1));
        tick();
        in_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c++;
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL single cyc%0d: got %h want %h", c, o, e);
            end
            tick();
        end
    endtask

    task automatic test_busy_reject();
        exp_t o, e;
        int c = 0;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        push_bytes(32'h12345678, 1'b0);
        sb.push_back(mk(8'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        tick();
        in_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c++;
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL busy_reject cyc%0d: got %h want %h", c, o, e);
            end
            if (c == 6) begin
                in_valid = 1'b1;
                in_data = 32'hAAAAAAAA;
            end
            if (c == 7) in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        int c = 0;
        in_valid = 1'b1;
        in_data = 32'hC0490FDB;
        push_bytes(32'hC0490FDB, 1'b0);
        sb.push_back(mk(8'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        push_bytes(32'h01020304, 1'b0);
        sb.push_back(mk(8'h00, 2'd0, 1'b0, 1'b1, 1'b1));
        tick();
        in_data = 32'h01020304;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c++;
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, o, e);
            end
            if (c == 18) in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        exp_t o, e;
        int c = 0;
        in_valid = 1'b1;
        in_data = 32'hCAFEF00D;
        push_bytes(32'hCAFEF00D, SHOW_RDY);
        while (sb.size() > 6) void'(sb.pop_back());
        repeat (12) sb.push_back(mk(8'h00, 2'd0, 1'b0, 1'b0, 1'b1));
        tick();
        in_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c++;
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL mid_reset cyc%0d: got %h want %h", c, o, e);
            end
            if (c == 6) rst = 1'b0;
            if (c == 7) rst = 1'b1;
            tick();
        end
    endtask

    task automatic test_repeat();
        exp_t o, e;
        int c = 0;
        in_valid = 1'b1;
        in_data = 32'h40490FDB;
        push_bytes(32'h40490FDB, 1'b1);
        sb.push_back(mk(8'h40, 2'd3, 1'b1, 1'b1, 1'b1));
        repeat (3) sb.push_back(mk(8'h40, 2'd3, 1'b1, 1'b0, 1'b1));
        for (int k = 2; k >= 0; k--)
            repeat (4) sb.push_back(mk(8'(32'h40490FDB >> (8*k)), 2'(k), 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(8'h40, 2'd3, 1'b1, 1'b1, 1'b1));
        sb.push_back(mk(8'h40, 2'd3, 1'b1, 1'b0, 1'b1));
        tick();
        in_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c++;
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL repeat cyc%0d: got %h want %h", c, o, e);
            end
            tick();
        end
    endtask

    task automatic test_repeat_interrupt();
        exp_t o, e;
        int c = 0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h40490FDB;
        push_bytes(32'h40490FDB, 1'b1);
        sb.push_back(mk(8'h40, 2'd3, 1'b1, 1'b1, 1'b1));
        repeat (3) sb.push_back(mk(8'h40, 2'd3, 1'b1, 1'b0, 1'b1));
        push_bytes(32'h11223344, 1'b1);
        sb.push_back(mk(8'h11, 2'd3, 1'b1, 1'b1, 1'b1));
        sb.push_back(mk(8'h11, 2'd3, 1'b1, 1'b0, 1'b1));
        tick();
        in_valid = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            c++;
            o = {ch, bidx, busy, done, in_ready};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL repeat_interrupt cyc%0d: got %h want %h", c, o, e);
            end
            if (c == 20) begin
                in_valid = 1'b1;
                in_data = 32'h11223344;
            end
            if (c == 21) in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
`ifdef DISP_REPEAT_EN
        test_mid_reset();
        test_repeat();
        test_repeat_interrupt();
`else
        test_single();
        test_busy_reject();
        test_back_to_back();
        test_mid_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
